// File: rtl/if_fetch_queue_pkg.sv
// Shared defines for the instruction fetch queue: bus widths, NOP encoding,
// fault cause code and the stored entry layout.
package if_fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [3:0] EXC_INST_MISALIGNED = 4'd0;

  // excp is the MSB so the entry packs to 65 bits as {excp, pc, inst}.
  typedef struct packed {
    logic              excp;
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  localparam int unsigned ENTRY_W = $bits(fq_entry_t);

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fq_ram.sv
// Entry storage for the fetch queue: register array with one synchronous
// write port and one asynchronous read port.
module fq_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-to-decode instruction queue. Outputs depend on registered state only,
// so an entry is visible to decode no earlier than the cycle after its push.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     in_allow_in,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_excp,
  input  logic                     id_allow_in,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("if_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  fq_entry_t     wr_entry, head;

  assign in_allow_in = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);

  assign push = in_valid & in_allow_in & ~flush;
  assign pop  = out_valid & id_allow_in & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: natural overflow is the modulo-DEPTH wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.excp = pc_misaligned(in_pc);
    wr_entry.pc   = in_pc;
    wr_entry.inst = in_inst;
  end

  fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fq_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    out_pc   = RESET_PC;
    out_inst = NOP_INST;
    out_excp = 1'b0;
    if (out_valid) begin
      out_pc   = head.pc;
      out_inst = head.inst;
      out_excp = head.excp;
    end
  end

  assign occupancy = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst_n;
  logic        in_valid, id_allow_in, flush;
  logic [31:0] in_pc, in_inst;
  logic        in_allow_in, out_valid, out_excp;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  occupancy;

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_allow_in (in_allow_in),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_excp    (out_excp),
    .id_allow_in (id_allow_in),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered list of entries; full/empty decided on the pre-edge size.
  task automatic model_step();
    ent_t e;
    bit   do_push, do_pop;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = id_allow_in && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc   = in_pc;
        e.inst = in_inst;
        e.excp = (in_pc % 4) != 0;
        mq.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_occupancy", 32'(occupancy), 32'(mq.size()));
      check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("m_in_allow_in", 32'(in_allow_in), 32'(mq.size() != DEPTH));
      if (mq.size() != 0) begin
        check("m_out_pc", out_pc, mq[0].pc);
        check("m_out_inst", out_inst, mq[0].inst);
        check("m_out_excp", 32'(out_excp), 32'(mq[0].excp));
      end else begin
        check("m_out_pc_idle", out_pc, RPC);
        check("m_out_inst_idle", out_inst, NOP);
        check("m_out_excp_idle", 32'(out_excp), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ida, input logic fl);
    in_valid    = v;
    in_pc       = pc;
    in_inst     = inst;
    id_allow_in = ida;
    flush       = fl;
    step();
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    id_allow_in = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_allow_in"}, 32'(in_allow_in), 32'd1);
    check({tag, "_out_pc"}, out_pc, RPC);
    check({tag, "_out_inst"}, out_inst, NOP);
    check({tag, "_out_excp"}, 32'(out_excp), 32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_pc   = '0;
    in_inst = '0;
    idle_inputs();
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check_reset_outputs("rst");

    // Two back-to-back pushes, decode stalled.
    drive(1'b1, 32'h0, 32'hAAAA_0001, 1'b0, 1'b0);
    check("first_push_visible", 32'(out_valid), 32'd1);
    drive(1'b1, 32'h4, 32'hAAAA_0002, 1'b0, 1'b0);
    idle_inputs();
    check("bb_occupancy", 32'(occupancy), 32'd2);
    check("bb_out_pc", out_pc, 32'h0);
    check("bb_out_inst", out_inst, 32'hAAAA_0001);

    // Fill, rejected fifth push, ordered drain.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    check("full_allow_in", 32'(in_allow_in), 32'd0);
    drive(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("full_occupancy", 32'(occupancy), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 32'(4 * i));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    idle_inputs();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Full with a same-cycle pop: the push must not land.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h40 + 32'(4 * i), 32'hC000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h50, 32'hC000_0050, 1'b1, 1'b0);
    idle_inputs();
    check("full_pop_no_push", 32'(occupancy), 32'd3);
    check("full_pop_head", out_pc, 32'h44);

    // Steady-state push+pop at occupancy 2 across several pointer wraps.
    do_reset();
    drive(1'b1, 32'h200, 32'hD000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 32'hD000_0001, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
      check("stream_occupancy", 32'(occupancy), 32'd2);
    end
    idle_inputs();
    check("stream_head_pc", out_pc, 32'h228);
    check("stream_head_inst", out_inst, 32'hD000_000A);

    // Flush wins over a simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(4 * i), 32'hE000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h30C, 32'hE000_0003, 1'b1, 1'b1);
    idle_inputs();
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_pc", out_pc, RPC);

    // Misaligned PC flags the entry but keeps the word.
    do_reset();
    drive(1'b1, 32'h0000_0102, 32'h1234_5678, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0104, 32'h9ABC_DEF0, 1'b0, 1'b0);
    idle_inputs();
    check("misal_excp", 32'(out_excp), 32'd1);
    check("misal_inst", out_inst, 32'h1234_5678);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle_inputs();
    check("aligned_excp", 32'(out_excp), 32'd0);
    check("aligned_pc", out_pc, 32'h104);

    // Reset overrides everything in flight.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h400 + 32'(4 * i), 32'hF000_0000, 1'b0, 1'b0);
    in_valid    = 1'b1;
    id_allow_in = 1'b1;
    flush       = 1'b1;
    rst_n       = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    check_reset_outputs("midrst");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      in_valid    = ($urandom_range(0, 9) < 6);
      id_allow_in = ($urandom_range(0, 1) == 1);
      in_pc       = $urandom;
      if ($urandom_range(0, 3) != 0) in_pc[1:0] = 2'b00;
      in_inst     = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
